// File: rtl/exu_lsu_pkg.sv
// Shared types and constants for the load/store responder.
package exu_lsu_pkg;

  localparam int LSU_TMO_W   = 8;
  localparam int LSU_TMO_CYC = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_st_e;

  // Bus-side view of the accepted request, held for the whole transaction
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic        we;
    logic        ren;
  } lsu_req_t;

  function automatic logic [31:0] word_adr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/exu_lsu_if.sv
// AGU-side handshake and data-bus bundles for exu_lsu.

// AGU <-> LSU: master is the AGU, slave is the LSU
interface exu_lsu_ag_if;
  logic        hs_ag4ls_val;
  logic        hs_ls4ag_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;

  modport master (
    output hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
    input  hs_ls4ag_rdy, o_ls_rdat, o_ls_err
  );
  modport slave (
    input  hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
    output hs_ls4ag_rdy, o_ls_rdat, o_ls_err
  );
endinterface

// LSU <-> data memory: master is the LSU, slave is the memory port
interface exu_lsu_bus_if;
  logic        o_bus_req;
  logic        i_bus_gnt;
  logic [31:0] o_bus_adr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdat;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdat;
  logic        i_bus_err;

  modport master (
    output o_bus_req, o_bus_adr, o_bus_we, o_bus_be, o_bus_wdat,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdat, i_bus_err
  );
  modport slave (
    input  o_bus_req, o_bus_adr, o_bus_we, o_bus_be, o_bus_wdat,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdat, i_bus_err
  );
endinterface

// File: rtl/exu_lsu_wdat_align.sv
// Store-data lane shift: moves the unshifted byte/half/word up to the lanes
// selected by the low address bits; lanes below the offset are zero.
module lsu_wdat_align #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8,
  localparam int SH_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES*VEC_W-1:0]        wdat,
  input  logic [SH_W-1:0]                   sh,
  output logic [NUM_LANES-1:0][VEC_W-1:0]   wdat_al
);

  logic [NUM_LANES-1:0][VEC_W-1:0] src;
  assign src = wdat;

  // Each output lane takes source lane (lane - sh), or zero when that underflows
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [SH_W-1:0] LN = SH_W'(l);
    logic [SH_W-1:0] src_idx;
    assign src_idx    = LN - sh;
    assign wdat_al[l] = (sh <= LN) ? src[src_idx] : '0;
  end

endmodule

// File: rtl/exu_lsu.sv
// Load/store responder: one aligned AGU request at a time, turned into a
// single req/gnt + rvalid data-bus transaction, with a cycle-budget timeout.
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int TMO_CYC = LSU_TMO_CYC,
  parameter int TMO_W   = LSU_TMO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  exu_lsu_ag_if.slave       ag,
  exu_lsu_bus_if.master     bus
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

  lsu_st_e          st_q, st_d;
  lsu_req_t         req_q, req_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [31:0]      wdat_al;
  logic             acc, tmo_hit;

  lsu_wdat_align #(.NUM_LANES(4), .VEC_W(8)) u_align (
    .wdat    (ag.i_ls_wdat),
    .sh      (ag.i_ls_adr[1:0]),
    .wdat_al (wdat_al)
  );

  assign acc     = ag.i_ls_ren | (|ag.i_ls_wen);
  assign tmo_inc = tmo_q + TMO_ONE;
  // Counter value after this cycle would equal the budget; a zero budget never fires
  assign tmo_hit = (TMO_CYC != 0) && (tmo_inc == TMO_LIM);

  // State, request, response and timeout registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      req_q  <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      tmo_q  <= '0;
    end else begin
      st_q   <= st_d;
      req_q  <= req_d;
      rdat_q <= rdat_d;
      err_q  <= err_d;
      tmo_q  <= tmo_d;
    end
  end

  // Next-state: accept, request, wait for response, one-cycle completion
  always_comb begin
    st_d   = st_q;
    req_d  = req_q;
    rdat_d = rdat_q;
    err_d  = err_q;
    tmo_d  = tmo_q;
    case (st_q)
      ST_IDLE: begin
        if (ag.hs_ag4ls_val) begin
          rdat_d = '0;
          err_d  = 1'b0;
          if (acc) begin
            req_d.adr  = word_adr(ag.i_ls_adr);
            req_d.wdat = wdat_al;
            req_d.we   = |ag.i_ls_wen;
            req_d.be   = ag.i_ls_ren ? 4'b1111 : ag.i_ls_wen;
            req_d.ren  = ag.i_ls_ren;
            tmo_d      = '0;
            st_d       = ST_REQ;
          end else begin
            // Neither load nor store: complete without touching the bus
            st_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        // rvalid is not meaningful before the grant
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          rdat_d = '0;
          err_d  = 1'b1;
          st_d   = ST_DONE;
        end else if (bus.i_bus_gnt) begin
          st_d = ST_RSP;
        end
      end
      ST_RSP: begin
        tmo_d = tmo_inc;
        // A response in the timeout cycle still counts as a normal completion
        if (bus.i_bus_rvalid) begin
          rdat_d = req_q.ren ? bus.i_bus_rdat : '0;
          err_d  = bus.i_bus_err;
          st_d   = ST_DONE;
        end else if (tmo_hit) begin
          rdat_d = '0;
          err_d  = 1'b1;
          st_d   = ST_DONE;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign ag.hs_ls4ag_rdy = (st_q == ST_DONE);
  assign ag.o_ls_rdat    = rdat_q;
  assign ag.o_ls_err     = err_q;

  assign bus.o_bus_req   = (st_q == ST_REQ);
  assign bus.o_bus_adr   = req_q.adr;
  assign bus.o_bus_we    = req_q.we;
  assign bus.o_bus_be    = req_q.be;
  assign bus.o_bus_wdat  = req_q.wdat;

  // A request is either a load or a store, never both
  a_ld_st_excl: assert property (@(posedge clk) disable iff (!rst_n)
    ag.hs_ag4ls_val |-> !(ag.i_ls_ren && (|ag.i_ls_wen)));

endmodule

// File: tb/tb_exu_lsu.sv
module tb_exu_lsu;

  logic        clk, rst_n;
  logic        val, val_t, ren, gnt, rvalid, berr;
  logic [31:0] adr, wdat, bdat;
  logic [3:0]  wen;
  int          n_vec, n_mis;

  exu_lsu_ag_if  ag();
  exu_lsu_bus_if bus();
  exu_lsu_ag_if  ag_t();
  exu_lsu_bus_if bus_t();

  assign ag.hs_ag4ls_val   = val;
  assign ag_t.hs_ag4ls_val = val_t;
  assign ag.i_ls_adr    = adr;   assign ag_t.i_ls_adr  = adr;
  assign ag.i_ls_wdat   = wdat;  assign ag_t.i_ls_wdat = wdat;
  assign ag.i_ls_wen    = wen;   assign ag_t.i_ls_wen  = wen;
  assign ag.i_ls_ren    = ren;   assign ag_t.i_ls_ren  = ren;
  assign bus.i_bus_gnt    = gnt;    assign bus_t.i_bus_gnt    = gnt;
  assign bus.i_bus_rvalid = rvalid; assign bus_t.i_bus_rvalid = rvalid;
  assign bus.i_bus_rdat   = bdat;   assign bus_t.i_bus_rdat   = bdat;
  assign bus.i_bus_err    = berr;   assign bus_t.i_bus_err    = berr;

  exu_lsu dut (.clk(clk), .rst_n(rst_n), .ag(ag.slave), .bus(bus.master));
  exu_lsu #(.TMO_CYC(4), .TMO_W(3)) dut_t (.clk(clk), .rst_n(rst_n), .ag(ag_t.slave), .bus(bus_t.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; val = 0; val_t = 0; gnt = 0; rvalid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one request on dut with a bus responder that grants after gd
  // ungranted req cycles and answers after rd idle response cycles.
  task automatic run_xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wn,
      input logic rn, input int gd, input int rd, input logic [31:0] rsp_d, input logic rsp_e,
      input bit drop, output int lat, output int nreq, output bit moved,
      output logic [31:0] r_dat, output logic r_err, output logic [31:0] b_adr,
      output logic b_we, output logic [3:0] b_be, output logic [31:0] b_wdat);
    int  rsp_cnt;
    bit  in_rsp;
    lat = -1; nreq = 0; moved = 0; rsp_cnt = 0; in_rsp = 0;
    r_dat = '0; r_err = 1'b0; b_adr = '0; b_we = 1'b0; b_be = '0; b_wdat = '0;
    @(negedge clk);
    val = 1; adr = a; wdat = wd; wen = wn; ren = rn; gnt = 0; rvalid = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      gnt = 0; rvalid = 0; bdat = $urandom; berr = 1'($urandom);
      if (drop && cyc == 1) val = 0;
      if (ag.hs_ls4ag_rdy) begin
        lat = cyc; r_dat = ag.o_ls_rdat; r_err = ag.o_ls_err; val = 0; break;
      end
      if (in_rsp) begin
        rsp_cnt++;
        if (rsp_cnt > rd) begin rvalid = 1; bdat = rsp_d; berr = rsp_e; end
      end
      if (bus.o_bus_req) begin
        if (nreq == 0) begin
          b_adr = bus.o_bus_adr; b_we = bus.o_bus_we; b_be = bus.o_bus_be; b_wdat = bus.o_bus_wdat;
        end else if ({b_adr, b_we, b_be, b_wdat} !== {bus.o_bus_adr, bus.o_bus_we, bus.o_bus_be, bus.o_bus_wdat})
          moved = 1;
        nreq++;
        // spurious rvalid before the grant must be ignored
        if ($urandom_range(0, 3) == 0) rvalid = 1;
        if (nreq > gd) begin gnt = 1; in_rsp = 1; end
      end
    end
    val = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; val = 1; val_t = 1; adr = 32'h104; wdat = $urandom; wen = 0; ren = 1;
    gnt = 1; rvalid = 1; bdat = $urandom; berr = 1;
    repeat (3) @(negedge clk);
    n_vec++; if ({ag.hs_ls4ag_rdy, ag.o_ls_err, ag.o_ls_rdat} !== 34'd0) begin n_mis++;
      $display("FAIL reset_ag: got %h want 0", {ag.hs_ls4ag_rdy, ag.o_ls_err, ag.o_ls_rdat}); end
    n_vec++; if ({bus.o_bus_req, bus.o_bus_adr, bus.o_bus_we, bus.o_bus_be, bus.o_bus_wdat} !== 70'd0) begin n_mis++;
      $display("FAIL reset_bus: got %h want 0", {bus.o_bus_req, bus.o_bus_adr, bus.o_bus_we, bus.o_bus_be, bus.o_bus_wdat}); end
    n_vec++; if ({ag_t.hs_ls4ag_rdy, ag_t.o_ls_err, ag_t.o_ls_rdat} !== 34'd0) begin n_mis++;
      $display("FAIL reset_ag_t: got %h want 0", {ag_t.hs_ls4ag_rdy, ag_t.o_ls_err, ag_t.o_ls_rdat}); end
    n_vec++; if ({bus_t.o_bus_req, bus_t.o_bus_adr, bus_t.o_bus_we, bus_t.o_bus_be, bus_t.o_bus_wdat} !== 70'd0) begin n_mis++;
      $display("FAIL reset_bus_t: got %h want 0", {bus_t.o_bus_req, bus_t.o_bus_adr, bus_t.o_bus_we, bus_t.o_bus_be, bus_t.o_bus_wdat}); end
    val = 0; val_t = 0; gnt = 0; rvalid = 0; berr = 0;
    rst_n = 1;
  endtask

  task automatic test_lw();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    run_xact(32'h100, 32'h0, 4'b0, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if (lat !== 3) begin n_mis++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_vec++; if (rd_ !== 32'hDEADBEEF) begin n_mis++; $display("FAIL lw_rdat: got %h want deadbeef", rd_); end
    n_vec++; if (re_ !== 1'b0) begin n_mis++; $display("FAIL lw_err: got %b want 0", re_); end
    n_vec++; if ({ba, we_, be_} !== {32'h100, 1'b0, 4'b1111}) begin n_mis++;
      $display("FAIL lw_bus: got %h/%b/%b want 100/0/1111", ba, we_, be_); end
  endtask

  task automatic test_sb();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    run_xact(32'h203, 32'h000000A5, 4'b1000, 1'b0, 0, 1, 32'h5A5A5A5A, 1'b0, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if ({ba, we_, be_} !== {32'h200, 1'b1, 4'b1000}) begin n_mis++;
      $display("FAIL sb_bus: got %h/%b/%b want 200/1/1000", ba, we_, be_); end
    n_vec++; if (bw !== 32'hA5000000) begin n_mis++; $display("FAIL sb_wdat: got %h want a5000000", bw); end
    n_vec++; if ({lat, rd_, re_} !== {32'd4, 32'd0, 1'b0}) begin n_mis++;
      $display("FAIL sb_done: got lat %0d rdat %h err %b want 4/0/0", lat, rd_, re_); end
  endtask

  task automatic test_sh_stall();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    // grant on the fifth req cycle: req held for 5 cycles
    run_xact(32'h302, 32'h0000BEEF, 4'b1100, 1'b0, 4, 0, 32'h0, 1'b0, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if (nreq !== 5) begin n_mis++; $display("FAIL sh_req_cycles: got %0d want 5", nreq); end
    n_vec++; if (mv !== 1'b0) begin n_mis++; $display("FAIL sh_stable: bus outputs moved while req held"); end
    n_vec++; if ({ba, bw, be_} !== {32'h300, 32'hBEEF0000, 4'b1100}) begin n_mis++;
      $display("FAIL sh_bus: got %h/%h/%b want 300/beef0000/1100", ba, bw, be_); end
    n_vec++; if (lat !== 7) begin n_mis++; $display("FAIL sh_latency: got %0d want 7", lat); end
  endtask

  task automatic test_bus_err();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    run_xact(32'h400, 32'h0, 4'b0, 1'b1, 1, 2, 32'h12345678, 1'b1, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if ({lat, re_} !== {32'd6, 1'b1}) begin n_mis++; $display("FAIL berr_done: got lat %0d err %b want 6/1", lat, re_); end
    run_xact(32'h404, 32'h0, 4'b0, 1'b1, 0, 0, 32'hCAFEF00D, 1'b0, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if ({lat, rd_, re_} !== {32'd3, 32'hCAFEF00D, 1'b0}) begin n_mis++;
      $display("FAIL berr_next: got lat %0d rdat %h err %b want 3/cafef00d/0", lat, rd_, re_); end
  endtask

  task automatic test_val_drop();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    run_xact(32'h44, 32'h11223344, 4'b1111, 1'b0, 2, 1, 32'hFFFFFFFF, 1'b0, 1, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if ({lat, rd_, bw} !== {32'd6, 32'd0, 32'h11223344}) begin n_mis++;
      $display("FAIL val_drop: got lat %0d rdat %h wdat %h want 6/0/11223344", lat, rd_, bw); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int k, sz, off, gd, rd, lat, nreq; bit mv;
      logic [31:0] a, wd, rsp, rd_, ba, bw, e_wdat; logic [3:0] wn, be_; logic rn, rerr, re_, we_;
      k = $urandom_range(0, 6);
      sz = (k % 3 == 0) ? 1 : (k % 3 == 1) ? 2 : 4;
      a = $urandom; a = a & ~32'(sz - 1); off = int'(a[1:0]);
      wd = $urandom; if (sz < 4) wd = wd & ((32'd1 << (8 * sz)) - 32'd1);
      rn = (k < 3);
      wn = (k >= 3 && k < 6) ? 4'(((1 << sz) - 1) << off) : 4'b0;
      gd = $urandom_range(0, 6); rd = $urandom_range(0, 4);
      rsp = $urandom; rerr = ($urandom_range(0, 7) == 0);
      run_xact(a, wd, wn, rn, gd, rd, rsp, rerr, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
      if (k == 6) begin
        n_vec++; if ({lat, nreq, rd_, re_} !== {32'd1, 32'd0, 32'd0, 1'b0}) begin n_mis++;
          $display("FAIL rnd_null[%0d]: got lat %0d nreq %0d rdat %h err %b want 1/0/0/0", n, lat, nreq, rd_, re_); end
      end else begin
        e_wdat = wd * (32'd1 << (8 * off));
        n_vec++; if (lat !== 3 + gd + rd || nreq !== gd + 1 || mv !== 1'b0) begin n_mis++;
          $display("FAIL rnd_timing[%0d]: got lat %0d nreq %0d moved %b want %0d/%0d/0", n, lat, nreq, mv, 3 + gd + rd, gd + 1); end
        n_vec++; if ({ba, we_, be_} !== {a - 32'(off), (k >= 3), (rn ? 4'hF : wn)}) begin n_mis++;
          $display("FAIL rnd_bus[%0d]: got %h/%b/%b want %h/%b/%b", n, ba, we_, be_, a - 32'(off), (k >= 3), (rn ? 4'hF : wn)); end
        if (k >= 3) begin
          n_vec++; if (bw !== e_wdat) begin n_mis++; $display("FAIL rnd_wdat[%0d]: got %h want %h", n, bw, e_wdat); end
        end
        n_vec++; if ({rd_, re_} !== {(rn ? rsp : 32'd0), rerr}) begin n_mis++;
          $display("FAIL rnd_rsp[%0d]: got %h/%b want %h/%b", n, rd_, re_, (rn ? rsp : 32'd0), rerr); end
      end
    end
  endtask

  task automatic test_rst_in_rsp();
    int lat, nreq; bit mv; logic [31:0] rd_, ba, bw; logic re_, we_; logic [3:0] be_;
    @(negedge clk); val = 1; adr = 32'h88; wen = 0; ren = 1;
    @(negedge clk); gnt = 1;                         // REQ
    @(negedge clk); gnt = 0; rst_n = 0; val = 0;     // RSP, reset applied
    @(negedge clk);
    n_vec++; if ({ag.hs_ls4ag_rdy, ag.o_ls_err, ag.o_ls_rdat, bus.o_bus_req, bus.o_bus_adr, bus.o_bus_we, bus.o_bus_be, bus.o_bus_wdat} !== 104'd0) begin
      n_mis++; $display("FAIL rst_rsp_outputs: got %h want 0", {ag.hs_ls4ag_rdy, ag.o_ls_err, ag.o_ls_rdat, bus.o_bus_req, bus.o_bus_adr, bus.o_bus_we, bus.o_bus_be, bus.o_bus_wdat}); end
    rst_n = 1;
    run_xact(32'h8C, 32'h0, 4'b0, 1'b1, 0, 0, 32'h0BADCAFE, 1'b0, 0, lat, nreq, mv, rd_, re_, ba, we_, be_, bw);
    n_vec++; if ({lat, rd_, re_, ba} !== {32'd3, 32'h0BADCAFE, 1'b0, 32'h8C}) begin n_mis++;
      $display("FAIL rst_rsp_next: got lat %0d rdat %h err %b adr %h want 3/0badcafe/0/8c", lat, rd_, re_, ba); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk); val_t = 1; adr = 32'h80; wen = 0; ren = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      rvalid = (cyc == 6 || cyc == 8); bdat = $urandom; berr = 0;
      n_vec++; if (ag_t.hs_ls4ag_rdy !== (cyc == 5) || bus_t.o_bus_req !== (cyc <= 4)) begin n_mis++;
        $display("FAIL tmo_cycle%0d: got rdy %b req %b want %b/%b", cyc, ag_t.hs_ls4ag_rdy, bus_t.o_bus_req, (cyc == 5), (cyc <= 4)); end
      if (cyc == 5) begin
        n_vec++; if ({ag_t.o_ls_err, ag_t.o_ls_rdat} !== {1'b1, 32'd0}) begin n_mis++;
          $display("FAIL tmo_result: got err %b rdat %h want 1/0", ag_t.o_ls_err, ag_t.o_ls_rdat); end
        val_t = 0;
      end
    end
    rvalid = 0;
  endtask

  task automatic test_tmo_race();
    do_reset();
    @(negedge clk); val_t = 1; adr = 32'h90; wen = 0; ren = 1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      gnt = (cyc == 1); rvalid = (cyc == 4); bdat = (cyc == 4) ? 32'h13572468 : 32'hFFFFFFFF; berr = 0;
      n_vec++; if (ag_t.hs_ls4ag_rdy !== (cyc == 5)) begin n_mis++;
        $display("FAIL race_rdy%0d: got %b want %b", cyc, ag_t.hs_ls4ag_rdy, (cyc == 5)); end
      if (cyc == 5) begin
        n_vec++; if ({ag_t.o_ls_err, ag_t.o_ls_rdat} !== {1'b0, 32'h13572468}) begin n_mis++;
          $display("FAIL race_result: got err %b rdat %h want 0/13572468", ag_t.o_ls_err, ag_t.o_ls_rdat); end
        val_t = 0;
      end
    end
    gnt = 0; rvalid = 0;
  endtask

  initial begin
    n_vec = 0; n_mis = 0;
    rst_n = 0; val = 0; val_t = 0; adr = 0; wdat = 0; wen = 0; ren = 0;
    gnt = 0; rvalid = 0; bdat = 0; berr = 0;
    test_reset();
    test_lw();
    test_sb();
    test_sh_stall();
    test_bus_err();
    test_val_drop();
    test_random();
    test_rst_in_rsp();
    test_timeout();
    test_tmo_race();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
